// File: rtl/mmio_port_hub.sv
// Memory-mapped I/O hub: input channels, output registers with write strobes, edge-triggered IRQs.
// Define MMIO_PORT_HUB_IRQ_EN to build the interrupt controller; otherwise INTR is tied low.
module mmio_port_hub #(
    parameter int unsigned N_IN      = 6,
    parameter int unsigned N_OUT     = 5,
    parameter int unsigned N_IRQ     = 2,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] IN_BASE   = 32'h1100_0000,
    parameter logic [31:0] OUT_BASE  = 32'h1140_0000,
    parameter logic [31:0] CTRL_BASE = 32'h11F0_0000,
    parameter logic [31:0] STRIDE    = 32'h0004_0000
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [31:0]             IOBUS_ADDR,
    input  logic [31:0]             IOBUS_OUT,
    input  logic                    IOBUS_WR,
    output logic [31:0]             IOBUS_IN,
    input  logic [N_IN*DATA_W-1:0]  IN_DATA,
    output logic [N_OUT*DATA_W-1:0] OUT_DATA,
    output logic [N_OUT-1:0]        OUT_WSTB,
    input  logic [N_IRQ-1:0]        IRQ_SRC,
    output logic                    INTR
);

    logic [N_OUT*DATA_W-1:0] out_q;
    logic [N_OUT-1:0]        wstb_q;
    logic [N_OUT-1:0]        wr_hit;
    logic [31:0]             ctrl_rdata;

    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (IOBUS_WR && (IOBUS_ADDR == OUT_BASE + 32'(j) * STRIDE)) begin
                wr_hit[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q  <= '0;
            wstb_q <= '0;
        end else begin
            wstb_q <= wr_hit;
            for (int j = 0; j < N_OUT; j++) begin
                if (wr_hit[j]) begin
                    out_q[j*DATA_W +: DATA_W] <= IOBUS_OUT[DATA_W-1:0];
                end
            end
        end
    end

    assign OUT_DATA = out_q;
    assign OUT_WSTB = wstb_q;

    // Read mux: lowest input channel first, then outputs, then control registers.
    always_comb begin
        logic hit;
        hit      = 1'b0;
        IOBUS_IN = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!hit && (IOBUS_ADDR == IN_BASE + 32'(i) * STRIDE)) begin
                IOBUS_IN[DATA_W-1:0] = IN_DATA[i*DATA_W +: DATA_W];
                hit = 1'b1;
            end
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (!hit && (IOBUS_ADDR == OUT_BASE + 32'(j) * STRIDE)) begin
                IOBUS_IN[DATA_W-1:0] = out_q[j*DATA_W +: DATA_W];
                hit = 1'b1;
            end
        end
        if (!hit) begin
            IOBUS_IN = ctrl_rdata;
        end
    end

`ifdef MMIO_PORT_HUB_IRQ_EN
    logic [N_IRQ-1:0] sync1_q, sync2_q, hist_q, pend_q, mask_q;
    logic [N_IRQ-1:0] edge_det, pend_d;
    logic             pend_wr, mask_wr;

    assign pend_wr  = IOBUS_WR && (IOBUS_ADDR == CTRL_BASE);
    assign mask_wr  = IOBUS_WR && (IOBUS_ADDR == CTRL_BASE + STRIDE);
    assign edge_det = sync2_q & ~hist_q;

    // A new edge wins over a simultaneous write-1-to-clear of the same bit.
    always_comb begin
        pend_d = pend_q;
        if (pend_wr) begin
            pend_d = pend_d & ~IOBUS_OUT[N_IRQ-1:0];
        end
        pend_d = pend_d | edge_det;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
        end else begin
            sync1_q <= IRQ_SRC;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            pend_q  <= pend_d;
            if (mask_wr) begin
                mask_q <= IOBUS_OUT[N_IRQ-1:0];
            end
        end
    end

    always_comb begin
        ctrl_rdata = '0;
        if (IOBUS_ADDR == CTRL_BASE) begin
            ctrl_rdata[N_IRQ-1:0] = pend_q;
        end else if (IOBUS_ADDR == CTRL_BASE + STRIDE) begin
            ctrl_rdata[N_IRQ-1:0] = mask_q;
        end
    end

    assign INTR = |(pend_q & mask_q);
`else
    logic unused_irq_src;

    assign unused_irq_src = ^IRQ_SRC;
    assign ctrl_rdata     = '0;
    assign INTR           = 1'b0;
`endif

endmodule

// File: doc/mmio_port_hub.md
# mmio_port_hub

Parametrised memory-mapped I/O hub between the OTTER MCU IOBUS and board peripherals. It provides N_IN read-only input channels, N_OUT read/write output registers with one-cycle write strobes, and an edge-triggered interrupt controller with pending and mask registers. It replaces hand-written per-board address case statements. It drives the MCU `INTR` input from any number of peripheral interrupt sources.

## Interface
- `N_IN`, 6: number of input channels (1–16).
- `N_OUT`, 5: number of output registers (1–16).
- `N_IRQ`, 2: number of interrupt sources (1–16).
- `DATA_W`, 32: channel/register width (≤32; IOBUS_IN zero-extended).
- `IN_BASE`, 32'h11000000: address of input channel 0.
- `OUT_BASE`, 32'h11400000: address of output register 0.
- `CTRL_BASE`, 32'h11F00000: address of IRQ pending register; mask at CTRL_BASE+STRIDE.
- `STRIDE`, 32'h00040000: address step between consecutive channels/registers.
- `CLK`  in  1  system clock (50 MHz sclk domain).
- `RST_N`  in  1  reset; one clock; reset is asynchronous and active-low.
- `IOBUS_ADDR`  in  32  CPU MMIO address.
- `IOBUS_OUT`  in  32  CPU write data.
- `IOBUS_WR`  in  1  CPU write enable.
- `IOBUS_IN`  out  32  read data to CPU (combinational).
- `IN_DATA`  in  N_IN*DATA_W  flattened input channels, channel i at [i*DATA_W +: DATA_W].
- `OUT_DATA`  out  N_OUT*DATA_W  flattened output registers.
- `OUT_WSTB`  out  N_OUT  per-register write strobe.
- `IRQ_SRC`  in  N_IRQ  interrupt sources, asynchronous to CLK.
- `INTR`  out  1  interrupt request to MCU.

## Operation
- Decode is an exact 32-bit compare: input i at IN_BASE+i*STRIDE, output j at OUT_BASE+j*STRIDE, pending at CTRL_BASE, mask at CTRL_BASE+STRIDE. No partial decode.
- Read mux priority when regions overlap: input channel > output register > control. Unmapped read returns 0.
- Reading an output address returns the current OUT_DATA register (readback). Reading pending or mask returns it zero-extended.
- Write to output j with IOBUS_WR=1:
  - OUT_DATA[j] <= IOBUS_OUT[DATA_W-1:0].
  - OUT_WSTB[j] is high for exactly the following cycle, then low.
- Writes to input-channel or unmapped addresses are ignored.
- Mask write: mask <= IOBUS_OUT[N_IRQ-1:0].
- Pending write is write-1-to-clear: pending <= pending & ~IOBUS_OUT[N_IRQ-1:0].
- Per source k: two-flop synchroniser s1→s2, history flop h, edge = s2 & ~h.
- pending[k] is set on edge. On the same cycle, a set beats a W1C clear of the same bit.
- INTR = |(pending & mask), combinational from registers.
- Reset values:
  - OUT_DATA 0, OUT_WSTB 0, pending 0, mask 0, INTR 0, s1/s2/h 0.
  - IOBUS_IN follows decode.
- A source held high across reset release produces one pending set (h resets to 0). This is intended.
- Reset asserted mid-write aborts it. The register stays 0 and no strobe is issued after release.

## Timing
- Read: zero latency, IOBUS_IN valid in the same cycle as IOBUS_ADDR.
- Write: OUT_DATA and OUT_WSTB update at the first rising edge with IOBUS_WR=1. The strobe stays high during the cycle after that edge.
- Back-to-back writes to the same register keep OUT_WSTB high continuously, one cycle per write. The last written value wins.
- IRQ: source rises before edge 1 → s1 at edge 1, s2 at edge 2, pending and INTR at edge 3.
- Sources must stay high and stay low for ≥2 CLK periods each. Shorter pulses may be missed.
- Mask change affects INTR in the same cycle the mask register updates (edge of the write).

## Configuration
- `MMIO_PORT_HUB_IRQ_EN` defined: the interrupt controller is built as described.
- Not defined:
  - Synchronisers, pending and mask are removed.
  - INTR is tied to 0.
  - Control addresses read 0; writes to them are ignored.
  - IRQ_SRC is unused.

## Test plan
- Reset then read: assert RST_N=0 mid-run → OUT_DATA=0, OUT_WSTB=0, INTR=0. Read IN_BASE+2*STRIDE with IN_DATA ch2=32'hDEAD → IOBUS_IN=32'h0000DEAD same cycle.
- Write and readback:
  - Write 32'hA5A5 to OUT_BASE+STRIDE → OUT_DATA ch1=32'hA5A5 and OUT_WSTB=5'b00010 for one cycle.
  - Reading the same address returns 32'hA5A5.
  - Writing IN_BASE leaves every OUT_DATA unchanged.
- Unmapped access: read 32'h11000004 → 0; write it → no strobe, no register change.
- IRQ latency and mask:
  - Mask=2'b01, raise IRQ_SRC[0] → INTR=1 at edge 3.
  - Raise IRQ_SRC[1] → pending=2'b11, INTR unchanged.
  - W1C 2'b01 → INTR=0.
- Simultaneous events: edge on IRQ_SRC[0] in the same cycle as W1C 2'b01 → pending[0] remains 1.
- Macro off: build without `MMIO_PORT_HUB_IRQ_EN`, toggle IRQ_SRC → INTR stays 0, CTRL_BASE reads 0.
